// File: rtl/if_id_skid_pkg.sv
// Shared defines for the IF/ID skid buffer: canonical NOP, default reset PC and
// the occupancy-state encoding (the state value doubles as the entry count).
package if_id_skid_pkg;

    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/if_id_entry.sv
// One held pipeline entry: valid bit plus PC/instruction with load enable.
// Latency 1 cycle from load; no backpressure (load has priority over clr).
module if_id_entry #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] RESET_INST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clr,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
);

    // clr only drops the valid bit; data stays so the PC output holds its value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            inst  <= RESET_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID two-entry skid buffer: 1-cycle accept-to-valid latency, full throughput.
// Backpressure: in_ready_o is a register (low only when the skid entry is full).
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(DEF_NOP_INST),
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [XLEN-1:0] in_inst_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_inst_o,
    output logic [1:0]      count_o
);

    state_e state_q, state_d;
    logic   rdy_q;

    logic            main_load, main_clr, main_from_skid;
    logic            skid_load, skid_clr;
    logic            main_valid, skid_valid;
    logic [XLEN-1:0] main_pc, main_inst, skid_pc, skid_inst;
    logic [XLEN-1:0] main_d_pc, main_d_inst;
    logic            accept, consume;

    assign accept  = in_valid_i & rdy_q;
    assign consume = main_valid & out_ready_i;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (consume) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    state_d  = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_TWO);
        end
    end

    assign main_d_pc   = main_from_skid ? skid_pc   : in_pc_i;
    assign main_d_inst = main_from_skid ? skid_inst : in_inst_i;

    if_id_entry #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .RESET_INST(NOP_INST)
    ) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (main_load),
        .clr      (main_clr),
        .load_pc  (main_d_pc),
        .load_inst(main_d_inst),
        .valid    (main_valid),
        .pc       (main_pc),
        .inst     (main_inst)
    );

    if_id_entry #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .RESET_INST(NOP_INST)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clr      (skid_clr),
        .load_pc  (in_pc_i),
        .load_inst(in_inst_i),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .inst     (skid_inst)
    );

    assign in_ready_o  = rdy_q;
    assign out_valid_o = main_valid;
    assign out_pc_o    = main_pc;
    assign out_inst_o  = main_valid ? main_inst : NOP_INST;
    assign count_o     = state_q;

endmodule
